// File: rtl/spi_adc2_rx.sv
// -----------------------------------------------------------------------------
// spi_adc2_rx
// Dual-channel SPI receiver for two AD7476A-style 12-bit ADCs that share one
// chip select and one serial clock. Each frame is 16 sclk periods, MSB first,
// with 4 leading zeros. Both data lines are shifted in together, and the lower
// 12 bits of each frame are presented with a one-cycle done strobe.
//
// Parameters
//   CLK_DIV  sclk half-period in clk cycles (1..255)
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active low
//   start   in   conversion request, sampled only while idle
//   sdata1  in   serial data, ADC channel 1
//   sdata2  in   serial data, ADC channel 2
//   cs      out  shared chip select, active low, registered
//   sclk    out  shared serial clock, idles high, registered
//   data1   out  last completed channel-1 sample
//   data2   out  last completed channel-2 sample
//   done    out  one-cycle strobe, data1/data2 valid from this cycle
//   busy    out  conversion in progress
// -----------------------------------------------------------------------------
module spi_adc2_rx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sdata1,
    input  logic        sdata2,
    output logic        cs,
    output logic        sclk,
    output logic [11:0] data1,
    output logic [11:0] data2,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        QUIET = 2'd3
    } state_e;

    // Wide enough for the QUIET terminal count 2*255-1.
    localparam int unsigned     CNT_W      = 10;
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(2 * CLK_DIV - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       bit_q;
    logic [15:0]      sr1_q;
    logic [15:0]      sr2_q;
    logic             cs_q;
    logic             sclk_q;
    logic [11:0]      data1_q;
    logic [11:0]      data2_q;
    logic             done_q;
    logic             busy_q;

    // NOTE: every register here, shift registers included, is a plain flop with
    // a reset value; there is no memory array, so clearing all of them on reset
    // costs nothing and keeps an aborted frame from leaking into the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr1_q   <= '0;
            sr2_q   <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            data1_q <= '0;
            data2_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge value of sclk_q/bit_q regardless of statement order.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SHIFT;
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        // sclk currently low and about to rise: capture both lines.
                        if (!sclk_q) begin
                            sr1_q <= {sr1_q[14:0], sdata1};
                            sr2_q <= {sr2_q[14:0], sdata2};
                            bit_q <= bit_q + 4'd1;
                            if (bit_q == 4'd15) begin
                                state_q <= HOLD;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        cs_q    <= 1'b1;
                        state_q <= QUIET;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                QUIET: begin
                    if (cnt_q == QUIET_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        data1_q <= sr1_q[11:0];
                        data2_q <= sr2_q[11:0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cs    = cs_q;
    assign sclk  = sclk_q;
    assign data1 = data1_q;
    assign data2 = data2_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_spi_adc2_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_adc2_rx
// Bench for spi_adc2_rx: one instance with CLK_DIV=4 driven by two ADC models,
// a second with CLK_DIV=1 for the short-divider case. Frame vectors live in a
// table; start-while-busy, back-to-back, reset-abort and CLK_DIV=1 are written
// out by hand.
// -----------------------------------------------------------------------------
module tb_spi_adc2_rx;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sdata1;
    logic        sdata2;
    logic        cs;
    logic        sclk;
    logic [11:0] data1;
    logic [11:0] data2;
    logic        done;
    logic        busy;

    logic        start_b;
    logic        sdata_b;
    logic        cs_b;
    logic        sclk_b;
    logic [11:0] data1_b;
    logic [11:0] data2_b;
    logic        done_b;
    logic        busy_b;

    int total;
    int bad;

    spi_adc2_rx #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sdata1(sdata1), .sdata2(sdata2),
        .cs(cs), .sclk(sclk), .data1(data1), .data2(data2), .done(done), .busy(busy)
    );

    spi_adc2_rx #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .sdata1(sdata_b), .sdata2(sdata_b),
        .cs(cs_b), .sclk(sclk_b), .data1(data1_b), .data2(data2_b), .done(done_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC models: after each falling sclk while selected, present the next
    // frame bit (MSB first); chip-select fall rewinds to bit 15.
    logic [15:0] frame1, frame2, frame_b;
    int idx_a, idx_b;
    int rise_cnt, cs_fall, rise_cnt_b;

    initial begin
        idx_a = 15; idx_b = 15; sdata1 = 1'b0; sdata2 = 1'b0; sdata_b = 1'b0;
        rise_cnt = 0; cs_fall = 0; rise_cnt_b = 0;
    end

    always @(negedge cs) begin
        idx_a = 15;
        cs_fall++;
    end
    always @(negedge sclk) begin
        if (!cs && idx_a >= 0) begin
            sdata1 = frame1[idx_a];
            sdata2 = frame2[idx_a];
            idx_a--;
        end
    end
    always @(posedge sclk) if (!cs) rise_cnt++;

    always @(negedge cs_b) idx_b = 15;
    always @(negedge sclk_b) begin
        if (!cs_b && idx_b >= 0) begin
            sdata_b = frame_b[idx_b];
            idx_b--;
        end
    end
    always @(posedge sclk_b) if (!cs_b) rise_cnt_b++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues start for exactly edge 0, optionally re-pulses it at edges p1/p2,
    // and returns the edge index after which done was first seen (-1 if none).
    task automatic do_conv(input logic [15:0] f1, input logic [15:0] f2,
                           input int p1, input int p2, output int done_edge);
        frame1   = f1;
        frame2   = f2;
        rise_cnt = 0;
        cs_fall  = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("cs_low_at_edge0", {31'd0, cs}, 32'd0);
        check("busy_at_edge0", {31'd0, busy}, 32'd1);
        check("sclk_high_at_edge0", {31'd0, sclk}, 32'd1);
        done_edge = -1;
        for (int e = 1; e <= 200 && done_edge < 0; e++) begin
            start = (e == p1) || (e == p2);
            @(posedge clk);
            #1;
            if (done) done_edge = e;
        end
        start = 1'b0;
        check("busy_low_in_done_cycle", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [15:0] f1;
        logic [15:0] f2;
        logic [11:0] exp1;
        logic [11:0] exp2;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int de;
        int de2;
        total = 0;
        bad   = 0;
        start = 1'b0;
        start_b = 1'b0;
        frame1 = '0; frame2 = '0; frame_b = '0;

        vecs[0] = '{16'h0ABC, 16'h0123, 12'hABC, 12'h123};
        vecs[1] = '{16'hF555, 16'h8FFF, 12'h555, 12'hFFF};
        vecs[2] = '{16'h0000, 16'h0FFF, 12'h000, 12'hFFF};

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", {31'd0, cs}, 32'd1);
        check("rst_sclk", {31'd0, sclk}, 32'd1);
        check("rst_data1", {20'd0, data1}, 32'd0);
        check("rst_data2", {20'd0, data2}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven single conversions
        for (int i = 0; i < 3; i++) begin
            do_conv(vecs[i].f1, vecs[i].f2, 0, 0, de);
            check("vec_done_edge", de, 32'd140);
            check("vec_data1", {20'd0, data1}, {20'd0, vecs[i].exp1});
            check("vec_data2", {20'd0, data2}, {20'd0, vecs[i].exp2});
            check("vec_sclk_rises", rise_cnt, 32'd16);
            check("vec_cs_falls", cs_fall, 32'd1);
            @(posedge clk); #1;
            check("vec_done_one_cycle", {31'd0, done}, 32'd0);
        end

        // Start while busy: re-pulses at edges 10 and 100 are ignored
        do_conv(16'h0321, 16'h0654, 10, 100, de);
        check("busy_start_done_edge", de, 32'd140);
        check("busy_start_cs_falls", cs_fall, 32'd1);
        check("busy_start_data1", {20'd0, data1}, 32'h321);
        check("busy_start_data2", {20'd0, data2}, 32'h654);
        repeat (5) @(posedge clk);
        #1;
        check("busy_start_stays_idle", {31'd0, cs}, 32'd1);

        // Back-to-back with start held high
        frame1 = 16'h0001; frame2 = 16'h0123;
        cs_fall = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        de = -1; de2 = -1;
        for (int e = 1; e <= 320 && de2 < 0; e++) begin
            @(posedge clk);
            #1;
            if (e == 200) check("b2b_data1_held", {20'd0, data1}, 32'h001);
            if (done) begin
                if (de < 0) begin
                    de = e;
                    check("b2b_first_data1", {20'd0, data1}, 32'h001);
                    frame1 = 16'h0FFE;
                end else begin
                    de2 = e;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_first_done_edge", de, 32'd140);
        check("b2b_second_done_edge", de2, 32'd281);
        check("b2b_second_data1", {20'd0, data1}, 32'hFFE);
        check("b2b_cs_falls", cs_fall, 32'd2);
        repeat (3) @(posedge clk);

        // Reset mid-conversion at edge 60
        frame1 = 16'h0777; frame2 = 16'h0888;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (60) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_cs", {31'd0, cs}, 32'd1);
        check("abort_sclk", {31'd0, sclk}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_data1", {20'd0, data1}, 32'd0);
        check("abort_data2", {20'd0, data2}, 32'd0);
        de = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) de++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (100) begin
            @(posedge clk); #1;
            if (done) de++;
        end
        check("abort_no_done", de, 32'd0);
        do_conv(16'h0BEE, 16'h0CAB, 0, 0, de);
        check("after_abort_done_edge", de, 32'd140);
        check("after_abort_data1", {20'd0, data1}, 32'hBEE);
        check("after_abort_data2", {20'd0, data2}, 32'hCAB);

        // CLK_DIV = 1 instance
        frame_b = 16'h0A5A;
        rise_cnt_b = 0;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        de = -1;
        for (int e = 1; e <= 80 && de < 0; e++) begin
            @(posedge clk);
            #1;
            if (done_b) de = e;
        end
        check("div1_done_edge", de, 32'd35);
        check("div1_data1", {20'd0, data1_b}, 32'hA5A);
        check("div1_data2", {20'd0, data2_b}, 32'hA5A);
        check("div1_sclk_rises", rise_cnt_b, 32'd16);
        check("div1_busy_done_cycle", {31'd0, busy_b}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_adc2_rx.md
# spi_adc2_rx

Dual-channel SPI ADC receiver that sits directly upstream of `spitouart_camp2`. It drives a shared chip-select and serial clock to two 12-bit ADCs (AD7476A-style, 16-clock frame, 4 leading zeros, MSB first). It shifts in both data lines simultaneously and presents `data1`/`data2` with a one-cycle `done` strobe. `spitouart_camp2` issues `start` and consumes `data1`, `data2` and `done`.

## Interface
- `CLK_DIV`, 4: `sclk` half-period in `clk` cycles; legal range 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  conversion request, level-sampled in IDLE only.
- `sdata1`  in  1  serial data from ADC channel 1.
- `sdata2`  in  1  serial data from ADC channel 2.
- `cs`  out  1  shared ADC chip select, active low; registered.
- `sclk`  out  1  shared serial clock, idles high; registered.
- `data1`  out  12  last completed channel-1 sample.
- `data2`  out  12  last completed channel-2 sample.
- `done`  out  1  one-cycle strobe; `data1`/`data2` are valid from this cycle.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- **States:** IDLE, SHIFT, HOLD, QUIET.
- **Reset (`rst`=0):**
  - Output values: `cs`=1, `sclk`=1, `data1`=`data2`=0, `done`=0, `busy`=0.
  - Internal state: IDLE, all counters and shift registers cleared.
  - Reset asserted mid-conversion aborts it immediately: no `done`, outputs keep their previous data (0 after reset).
- **IDLE:**
  - `cs`=1, `sclk`=1.
  - `start`=1 at a rising edge moves to SHIFT; `cs` goes 0 and `busy` goes 1 from that edge.
- **SHIFT:**
  - A half-period counter counts `CLK_DIV` cycles and toggles `sclk` at terminal count.
  - `sclk` stays high for the first `CLK_DIV` cycles after `cs` falls, then runs 16 full periods (low, then high).
  - At each clk edge where `sclk` is driven 0→1, `sdata1` and `sdata2` are shifted into two 16-bit shift registers, MSB first.
  - After the 16th rising `sclk`, go to HOLD.
- **HOLD:** `sclk`=1, `cs`=0 for `CLK_DIV` cycles, then `cs`=1 and go to QUIET.
- **QUIET:** `cs`=1, `sclk`=1 for 2·`CLK_DIV` cycles, then return to IDLE. On that transition edge:
  - `done`=1 for exactly one cycle.
  - `data1`/`data2` are loaded with shift-register bits [11:0].
  - `busy`=0.
- **Data rules:**
  - Bits [15:12] (leading zeros) are discarded and not checked.
  - `data1`/`data2` change only on `done` edges.
- `start` outside IDLE is ignored; there is no queuing.
- `start` high during the `done` cycle is accepted, since the state is IDLE.

## Timing
Edge 0 is the rising edge at which `start` is sampled high in IDLE. D = `CLK_DIV`.
- `cs`=0 from edge 0.
- `sclk` falling edges at edges D(2k+1), rising edges at edges 2D(k+1), for k = 0..15.
- Sample k is captured at edge 2D(k+1); the 16th sample is at edge 32D.
- `cs`=1 at edge 33D.
- `done`=1 during the cycle after edge 35D.
- Latency from `start` to `done` is 35D edges: 140 edges for D=4, 35 for D=1.
- With `start` held high, throughput is one conversion per 35D+1 cycles. The next `cs` fall is at the edge ending the `done` cycle.
- `busy` is high from edge 0 through edge 35D and low during the `done` cycle.
- Every `sclk`/`cs` transition is from a flop; there is no combinational path from `start` or `sdata*` to any output.

## Test plan
- **Single conversion:** D=4, ADC models shift frames 0x0ABC (ch1) and 0x0123 (ch2) on `sclk` falling edges. Expect:
  - `done` only after edge 140.
  - `data1`=12'hABC, `data2`=12'h123.
  - exactly 16 `sclk` rising edges while `cs`=0.
- **Leading bits ignored:** frames 0xF555 and 0x8FFF. Expect `data1`=12'h555, `data2`=12'hFFF.
- **Start while busy:** pulse `start` again at edges 10 and 100 of a running conversion. Expect:
  - a single `done` after edge 140.
  - no extra `cs` fall until after `done`.
- **Back-to-back:** hold `start` high with frames 0x0001 then 0x0FFE. Expect:
  - `done` strobes after edges 140 and 281.
  - `data1` = 12'h001, then 12'hFFE.
- **Reset mid-conversion:** assert `rst`=0 asynchronously at edge 60. Expect immediately `cs`=1, `sclk`=1, `busy`=0, `data1`=`data2`=0, `done` never pulses. A new `start` after release gives a normal 140-edge conversion.
- **CLK_DIV=1:** frame 0x0A5A on both channels. Expect `done` after edge 35 and `data1`=`data2`=12'hA5A.
